// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} bcd_state_t;

  // Minimum digit count d with 10**d > 2**w; 2**w is never a power of ten for w > 0,
  // so this is the decimal length of 2**w (log10(2) ~= 0.30103).
  function automatic int unsigned bcd_digits(input int unsigned w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/module_bin2bcd_seq_if.sv
// Start/done handshake and data bus between the multiplier top level and the converter.
interface module_bin2bcd_seq_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned DIGITS = 3
);
  logic                  start;
  logic [2*N-1:0]        p_in;
  logic                  busy;
  logic                  done;
  logic                  neg;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, p_in, input busy, done, neg, bcd);
  modport slave  (input start, p_in, output busy, done, neg, bcd);
endinterface

// File: rtl/module_bcd_add3.sv
// Double-dabble digit correction: digits of 5 or more get +3 before the shift.
module module_bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/module_bin2bcd_seq.sv
// Sequential double-dabble: product -> sign + packed BCD, one add-3/shift per clock.
// Define BIN2BCD_SIGNED_EN to treat p_in as two's complement; otherwise unsigned, neg tied 0.
module module_bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DIGITS = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  module_bin2bcd_seq_if.slave  bus
);

  localparam int unsigned W         = 2 * N;
  localparam int unsigned BW        = 4 * DIGITS;
  localparam int unsigned CW        = $clog2(W + 1);
  localparam int unsigned MinDigits = bcd_digits(W);

  if (DIGITS < MinDigits) begin : gen_digits_check
    $error("DIGITS too small for a %0d-bit product", W);
  end

  bcd_state_t      state_q, state_d;
  logic [W-1:0]    mag_q, mag_d;
  logic [BW-1:0]   scr_q, scr_d, scr_adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sgn_q, sgn_d;
  logic            neg_q, neg_d;
  logic            done_q, done_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [W-1:0]    mag_in;
  logic            sgn_in;

`ifdef BIN2BCD_SIGNED_EN
  // -2**(W-1) negates to itself, which read unsigned is the correct magnitude.
  assign sgn_in = bus.p_in[W-1];
  assign mag_in = sgn_in ? (~bus.p_in + 1'b1) : bus.p_in;
`else
  assign sgn_in = 1'b0;
  assign mag_in = bus.p_in;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : gen_add3
    module_bcd_add3 u_add3 (
      .digit_i (scr_q[4*i +: 4]),
      .digit_o (scr_adj[4*i +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mag_d   = mag_in;
          sgn_d   = sgn_in;
          scr_d   = '0;
          cnt_d   = CW'(W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, mag_d} = {scr_adj, mag_q} << 1;
        cnt_d          = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FINISH;
      end
      FINISH: begin
        bcd_d   = scr_q;
        neg_d   = sgn_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.neg  = neg_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_module_bin2bcd_seq.sv
// Self-checking bench for module_bin2bcd_seq (N=4, DIGITS=3) against a decimal-arithmetic model.
module tb_module_bin2bcd_seq;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  module_bin2bcd_seq_if #(.N(4), .DIGITS(3)) bus ();

  module_bin2bcd_seq #(.N(4), .DIGITS(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret the product, take |value|, split into decimal digits.
  function automatic void model(input logic [7:0] p, output logic [11:0] b, output logic ng);
    int v;
`ifdef BIN2BCD_SIGNED_EN
    v = int'($signed(p));
`else
    v = int'(p);
`endif
    ng = (v < 0);
    if (v < 0) v = -v;
    b = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Pulse start with p and wait for done; lat = cycles from acceptance to done (0 = timeout).
  task automatic run_conv(input logic [7:0] p, output logic [11:0] b, output logic ng,
                          output int lat, output int busy_cyc);
    lat = 0; b = '0; ng = 1'b0; busy_cyc = 0;
    bus.start = 1'b1;
    bus.p_in  = p;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.p_in  = 8'($urandom);
    if (bus.busy) busy_cyc++;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = c; b = bus.bcd; ng = bus.neg;
        break;
      end
      if (bus.busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.p_in  = '0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++; if (bus.neg  !== 1'b0) begin n_err++; $display("FAIL reset_neg: got %b want 0", bus.neg); end
    n_vec++; if (bus.bcd  !== 12'h000) begin n_err++; $display("FAIL reset_bcd: got %h want 000", bus.bcd); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0]  vecs [$];
    logic [11:0] b, eb;
    logic        ng, en;
    int          lat, bc;
`ifdef BIN2BCD_SIGNED_EN
    vecs = '{8'h15, 8'hC8, 8'h40, 8'h00, 8'h80, 8'h7F, 8'hFF};
`else
    vecs = '{8'hFF, 8'h15, 8'h80, 8'h00, 8'hC8, 8'h64};
`endif
    foreach (vecs[k]) begin
      model(vecs[k], eb, en);
      run_conv(vecs[k], b, ng, lat, bc);
      n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL dir_latency p=%h: got %0d want %0d", vecs[k], lat, W + 1); end
      n_vec++; if (b !== eb) begin n_err++; $display("FAIL dir_bcd p=%h: got %h want %h", vecs[k], b, eb); end
      n_vec++; if (ng !== en) begin n_err++; $display("FAIL dir_neg p=%h: got %b want %b", vecs[k], ng, en); end
      n_vec++; if (bc !== W) begin n_err++; $display("FAIL dir_busy p=%h: got %0d cycles want %0d", vecs[k], bc, W); end
      @(posedge clk); #1;
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL dir_done_pulse p=%h: got %b want 0", vecs[k], bus.done); end
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (bus.bcd !== eb || bus.neg !== en) begin
        n_err++; $display("FAIL dir_hold p=%h: got %h/%b want %h/%b", vecs[k], bus.bcd, bus.neg, eb, en);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [11:0] eb, b;
    logic        en, ng;
    int          ndone, lat;
    model(8'hC8, eb, en);
    ndone = 0; lat = 0; b = '0; ng = 1'b0;
    bus.start = 1'b1; bus.p_in = 8'hC8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3 || c == 5) begin bus.start = 1'b1; bus.p_in = 8'h15; end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin ndone++; lat = c; b = bus.bcd; ng = bus.neg; end
    end
    n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", ndone); end
    n_vec++; if (lat !== W + 1) begin n_err++; $display("FAIL ign_latency: got %0d want %0d", lat, W + 1); end
    n_vec++; if (b !== eb || ng !== en) begin n_err++; $display("FAIL ign_result: got %h/%b want %h/%b", b, ng, eb, en); end
  endtask

  task automatic test_async_reset();
    logic [11:0] b, eb;
    logic        ng, en;
    int          lat, bc, ndone;
    run_conv(8'h80, b, ng, lat, bc);
    bus.start = 1'b1; bus.p_in = 8'h99;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL arst_done: got %b want 0", bus.done); end
    n_vec++; if (bus.bcd !== 12'h000) begin n_err++; $display("FAIL arst_bcd: got %h want 000", bus.bcd); end
    n_vec++; if (bus.neg !== 1'b0) begin n_err++; $display("FAIL arst_neg: got %b want 0", bus.neg); end
    @(posedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL arst_no_done: got %0d want 0", ndone); end
    model(8'h5A, eb, en);
    run_conv(8'h5A, b, ng, lat, bc);
    n_vec++; if (lat !== W + 1 || b !== eb || ng !== en) begin
      n_err++; $display("FAIL arst_recover: got %0d/%h/%b want %0d/%h/%b", lat, b, ng, W + 1, eb, en);
    end
  endtask

  // Every code, issued back-to-back: next start is driven during the done cycle.
  task automatic test_sweep();
    logic [11:0] b, eb;
    logic        ng, en;
    int          lat, bc;
    for (int i = 0; i < 256; i++) begin
      model(8'(i), eb, en);
      run_conv(8'(i), b, ng, lat, bc);
      n_vec++; if (lat !== W + 1 || b !== eb || ng !== en) begin
        n_err++; $display("FAIL sweep p=%h: got %0d/%h/%b want %0d/%h/%b", 8'(i), lat, b, ng, W + 1, eb, en);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  p;
    logic [11:0] b, eb;
    logic        ng, en;
    int          lat, bc;
    for (int i = 0; i < 64; i++) begin
      p = 8'($urandom);
      model(p, eb, en);
      run_conv(p, b, ng, lat, bc);
      n_vec++; if (lat !== W + 1 || b !== eb || ng !== en) begin
        n_err++; $display("FAIL b2b p=%h: got %0d/%h/%b want %0d/%h/%b", p, lat, b, ng, W + 1, eb, en);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_async_reset();
    test_sweep();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
